aes_inv_keyexpansion: RTL
=========================

Name: aes_inv_keyexpansion

Overview:
Iterative inverse AES-128 key schedule for the decryption datapath. Loads the final round key (round 10) and walks the schedule backwards, emitting one 128-bit round key per handshake in order round 10, 9, ..., 0. Sits between the key source and the inverse cipher rounds, so decryption never needs all 11 expanded keys stored at once. Uses the existing sbox module for SubWord.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) is supported, and any other value is an elaboration error.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  load request; sampled only in IDLE
key_last  input  128  round-10 key, words {w40,w41,w42,w43}, w40 in [127:96]
rk  output  128  current round key, words {w4i..w4i+3}, registered
rk_round  output  4  round index of rk (10 down to 0)
rk_valid  output  1  rk/rk_round valid
rk_ready  input  1  consumer accepts rk this cycle
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the round-0 key is accepted

Behaviour:
- Reset: state=IDLE; rk=0, rk_round=0, rk_valid=0, busy=0, done=0. Reset mid-operation aborts the walk immediately, with no partial done.
- States: IDLE, EMIT.
- IDLE: start=1 -> next cycle rk=key_last, rk_round=10, rk_valid=1, busy=1, state=EMIT. start=0 -> stay in IDLE.
- EMIT, rk_valid & rk_ready:
  - rk_round>0: next cycle rk=prev(rk, rk_round), rk_round=rk_round-1, rk_valid stays 1.
  - rk_round=0: next cycle rk_valid=0, busy=0, done=1, state=IDLE. rk holds its last value.
- EMIT, rk_ready=0: rk, rk_round and rk_valid hold stable. This is ready/valid; the consumer may stall indefinitely.
- prev() for round key i = {a0,a1,a2,a3} produces key i-1 = {b0,b1,b2,b3}:
  - b3=a3^a2, b2=a2^a1, b1=a1^a0.
  - b0=a0^SubWord(RotWord(b3))^{Rcon[i],24'b0}.
  - RotWord({x0,x1,x2,x3}) = {x1,x2,x3,x0}.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Latency: start to first rk_valid is 1 cycle. With rk_ready held high, one key per cycle: round 10 on cycle 1, round 0 on cycle 11, done on cycle 12.
- start while busy (state EMIT): ignored; key_last is not resampled.
- start in the same cycle done is high: accepted (state is IDLE). The round-10 key appears on the next cycle.
- done and rk_valid are never high together.
- rk_round is never below 0, and Rcon index 0 is never used.
- key_last is only sampled on the accepted start cycle.

Decomposition:
- aes_pkg:
  - NR_128=10.
  - typedef word_t (logic [31:0]) and rkey_t (logic [127:0]).
  - function rcon(round 4-bit) -> 8-bit, returning 00 for out-of-range values.
  - functions rotword, and subword built on sbox instances at module level.
- Sub-module aes_inv_key_step: purely combinational prev(); inputs rk_i (128) and round (4), output rk_prev (128). Contains 4 sbox instances.
- The top holds the FSM, the rk register, the round counter and the handshake.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c; key_last=d014f9a8c9ee2589e13f0cc8b6630ca6, start, rk_ready=1:
  - round 10 equals key_last.
  - round 9 = ac7766f319fadc2128d12941575c006e.
  - round 1 = a0fafe1788542cb123a339392a6c7605.
  - round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - done on cycle 12.
- Same vector with rk_ready randomly deasserted (~50%): rk and rk_round stable while stalled; identical 11-key sequence; exactly one done pulse.
- start pulsed again during EMIT with a different key_last: ignored; the original sequence completes unchanged.
- rst asserted at round 5 mid-walk: next cycle rk_valid=0, busy=0, rk=0, done=0. A new start then yields the round-10 key one cycle later.
- All-zero key: key_last=b4ef5bcb3e92e21123e951cf6f8f188e; walk to round 0 = 0000...0000 with rk_round 10 down to 0.
- start asserted in the done cycle: done=1 and the next cycle rk_valid=1 with rk_round=10; back-to-back sequences have no gap beyond 1 cycle.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES-128 key schedule blocks.
package aes_pkg;

  localparam int NR_128 = 10;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] rkey_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } ks_state_t;

  // Out-of-range rounds return 00 so an unused step output stays harmless.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] rc;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic word_t rotword(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// One backward step of the AES-128 key schedule: round key i -> round key i-1.
module aes_inv_key_step
  import aes_pkg::*;
(
  input  rkey_t      rk_i,
  input  logic [3:0] round_i,
  output rkey_t      rk_prev_o
);

  word_t a0, a1, a2, a3;
  word_t b0, b1, b2, b3;
  word_t rot, sub;

  assign a0 = rk_i[127:96];
  assign a1 = rk_i[95:64];
  assign a2 = rk_i[63:32];
  assign a3 = rk_i[31:0];

  // Words 1..3 of the previous key come straight from adjacent XORs.
  assign b3 = a3 ^ a2;
  assign b2 = a2 ^ a1;
  assign b1 = a1 ^ a0;

  assign rot = rotword(b3);

  for (genvar g = 0; g < 4; g++) begin : g_subword
    sbox u_sbox (
      .in_i  (rot[8*g +: 8]),
      .out_o (sub[8*g +: 8])
    );
  end

  assign b0 = a0 ^ sub ^ {rcon(round_i), 24'h000000};

  assign rk_prev_o = {b0, b1, b2, b3};

endmodule

// File: rtl/sbox.sv
// AES forward S-box as a constant lookup table, byte 00 in the top row's MSB.
module sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] bit_off;

  assign bit_off = {in_i, 3'b000};
  assign out_o   = SBOX_TBL[(11'd2047 - bit_off) -: 8];

endmodule

// File: rtl/aes_inv_keyexpansion.sv
// Iterative inverse AES-128 key schedule: emits round keys 10 down to 0
// over a ready/valid handshake, one backward step per accepted key.
//
// state | meaning
// IDLE  | waiting for start; rk holds the last emitted key
// EMIT  | rk/rk_round offered to the consumer until accepted
module aes_inv_keyexpansion
  import aes_pkg::*;
#(
  parameter int NR = NR_128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_last,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  if (NR != NR_128) begin : g_nr_check
    $error("aes_inv_keyexpansion: only NR=10 (AES-128) is supported");
  end

  ks_state_t  state_q;
  rkey_t      rk_q;
  rkey_t      rk_d;
  logic [3:0] round_q;
  logic       valid_q;
  logic       busy_q;
  logic       done_q;

  aes_inv_key_step u_step (
    .rk_i      (rk_q),
    .round_i   (round_q),
    .rk_prev_o (rk_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rk_q    <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            rk_q    <= key_last;
            round_q <= LAST_ROUND;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          // valid is always high in EMIT, so ready alone completes the handshake
          if (rk_ready) begin
            if (round_q != 4'd0) begin
              rk_q    <= rk_d;
              round_q <= round_q - 4'd1;
            end else begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign rk       = rk_q;
  assign rk_round = round_q;
  assign rk_valid = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
